// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// A load hit returns the cached word with no added latency. A load miss fills
// the whole line from main memory, one word per beat, in ascending word order.
// A store always writes through to memory. It updates the cached word only
// when the line is already present; it never allocates a line.
module dmem_cache_ctrl #(
  parameter int LINES     = 16,
  parameter int LINEWORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [3:0]  ByteEnM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemStallM,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemReq,
  output logic        MemWe,
  input  logic        MemReady,
  input  logic [31:0] MemRData
);

  localparam int WRD_W  = $clog2(LINEWORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int IDX_LO = 2 + WRD_W;
  localparam int TAG_LO = IDX_LO + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINEWORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WRD_W-1:0]     r_cnt;
  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [3:0][7:0]      r_data [LINES][LINEWORDS];

  logic [WRD_W-1:0]     w_word;
  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic                 w_fill_we;
  logic                 w_fill_last;
  logic                 w_store_we;
  logic [1:0]           w_unused_lo;

  // Byte offset never selects anything here; the W stage does byte selection.
  assign w_unused_lo = ALUOutM[1:0];

  assign w_word = ALUOutM[IDX_LO-1:2];
  assign w_idx  = ALUOutM[TAG_LO-1:IDX_LO];
  assign w_tag  = ALUOutM[31:TAG_LO];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // State register; reset abandons any outstanding fill or write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, memory-side outputs, stall, and array write strobes.
  always_comb begin
    w_state_nxt = r_state;
    ReadDataM   = 32'h0;
    MemStallM   = 1'b0;
    MemAddr     = 32'h0;
    MemWData    = 32'h0;
    MemBE       = 4'h0;
    MemReq      = 1'b0;
    MemWe       = 1'b0;
    w_fill_we   = 1'b0;
    w_fill_last = 1'b0;
    w_store_we  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // A simultaneous read and write request is handled as a store.
        if (MemWriteM) begin
          MemStallM   = 1'b1;
          w_state_nxt = S_WRITE;
        end else if (MemReadM) begin
          if (w_hit) begin
            ReadDataM = r_data[w_idx][w_word];
          end else begin
            MemStallM   = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
      end

      S_FILL: begin
        MemReq    = 1'b1;
        MemAddr   = {w_tag, w_idx, r_cnt, 2'b00};
        // The stall stays high through the last beat; the load hits next cycle.
        MemStallM = 1'b1;
        if (MemReady) begin
          w_fill_we = 1'b1;
          if (r_cnt == LAST_WORD) begin
            w_fill_last = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        MemReq    = 1'b1;
        MemWe     = 1'b1;
        MemAddr   = {ALUOutM[31:2], 2'b00};
        MemWData  = WriteDataM;
        MemBE     = ByteEnM;
        // Releasing the stall on the accepting cycle lets the pipeline advance
        // on the same edge that retires the write.
        MemStallM = ~MemReady;
        if (MemReady) begin
          w_store_we  = w_hit;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs and strobes are held at zero while reset is asserted.
    if (reset) begin
      ReadDataM   = 32'h0;
      MemStallM   = 1'b0;
      MemAddr     = 32'h0;
      MemWData    = 32'h0;
      MemBE       = 4'h0;
      MemReq      = 1'b0;
      MemWe       = 1'b0;
      w_fill_we   = 1'b0;
      w_fill_last = 1'b0;
      w_store_we  = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // Fill beat counter: zeroed while idle and wraps naturally after the last word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_fill_we) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Valid bits: the only array state that is reset; a line becomes valid only
  // when its final beat lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_fill_last) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Tag and data arrays: fill words arrive in order; store hits merge only the
  // enabled byte lanes into the cached word.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[w_idx][r_cnt] <= MemRData;
    end
    if (w_fill_last) begin
      r_tag[w_idx] <= w_tag;
    end
    if (w_store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ByteEnM[b]) begin
          r_data[w_idx][w_word][b] <= WriteDataM[8*b +: 8];
        end
      end
    end
  end

endmodule
